// File: rtl/memtest_sweep_ctrl.sv
// memtest_sweep_ctrl
// Control block for the SDRAM memory tester: clock-step position, chip
// select, auto-sweep, PLL reconfiguration handshake, tester reset hold and
// BCD elapsed-time / mark-phase display counters.
// Optional feature macro: MEMTEST_AUTOSWEEP_EN enables the auto-sweep mode
// (cmd_auto and pass/fail driven step advance). Without it auto_mode is 0.

module memtest_sweep_ctrl #(
    parameter int              NUM_STEPS     = 38,
    parameter int              NUM_CHIPS     = 3,
    parameter int              BCD_DIGITS    = 4,
    parameter longint unsigned UNIT_CYCLES   = 64'd3_000_000_000,
    parameter longint unsigned BLINK_CYCLES  = 64'd5_000_000,
    parameter longint unsigned HOLD_CYCLES   = 64'd1_000_000,
    parameter int unsigned     AUTO_MIN_PASS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_up,
    input  logic                         cmd_down,
    input  logic                         cmd_retest,
    input  logic                         cmd_auto,
    input  logic                         cmd_chip,
    input  logic [31:0]                  pass_count,
    input  logic [31:0]                  fail_count,
    input  logic                         recfg_done,
    output logic                         recfg_req,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic [$clog2(NUM_CHIPS)-1:0] chip,
    output logic                         auto_mode,
    output logic                         tester_rst,
    output logic [4*BCD_DIGITS-1:0]      elapsed_bcd,
    output logic [2:0]                   mark_phase
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int CW = $clog2(NUM_CHIPS);
    localparam int DW = 4 * BCD_DIGITS;
    localparam int UW = (UNIT_CYCLES  > 64'd1) ? $clog2(UNIT_CYCLES)  : 1;
    localparam int BW = (BLINK_CYCLES > 64'd1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES  > 64'd1) ? $clog2(HOLD_CYCLES)  : 1;

    localparam logic [SW-1:0] STEP_LAST  = SW'(NUM_STEPS - 1);
    localparam logic [CW-1:0] CHIP_LAST  = CW'(NUM_CHIPS - 1);
    localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYCLES - 64'd1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 64'd1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 64'd1);

`ifdef MEMTEST_AUTOSWEEP_EN
    localparam logic AUTO_RESET = 1'b1;
`else
    localparam logic AUTO_RESET = 1'b0;
`endif

    typedef enum logic [1:0] {REQ, HOLD, RUN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   chip_q, chip_d;
    logic            auto_q, auto_d;
    logic [HW-1:0]   holdCnt_q, holdCnt_d;
    logic [UW-1:0]   unitCnt_q, unitCnt_d;
    logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [2:0]      mark_q, mark_d;
    logic [3:0]      cmdHist_q;

    logic riseUp, riseDown, riseRetest, riseChip, riseAuto;
    logic autoAdvance;
    logic goReq;

    assign riseUp     = cmd_up     & ~cmdHist_q[3];
    assign riseDown   = cmd_down   & ~cmdHist_q[2];
    assign riseRetest = cmd_retest & ~cmdHist_q[1];
    assign riseChip   = cmd_chip   & ~cmdHist_q[0];

`ifdef MEMTEST_AUTOSWEEP_EN
    logic autoHist_q;

    // Edge-detect history for the auto-sweep command.
    always_ff @(posedge clk) begin
        if (reset) begin
            autoHist_q <= 1'b0;
        end else begin
            autoHist_q <= cmd_auto;
        end
    end

    assign riseAuto    = cmd_auto & ~autoHist_q;
    assign autoAdvance = (state_q == RUN) && auto_q && (fail_count != 32'd0) &&
                         (pass_count >= 32'(AUTO_MIN_PASS)) && (step_q != STEP_LAST);
`else
    logic unused_autosweep;

    assign riseAuto         = 1'b0;
    assign autoAdvance      = 1'b0;
    assign unused_autosweep = ^{cmd_auto, pass_count, fail_count};
`endif

    // Increment a packed BCD value; each digit 9 rolls to 0 and carries on.
    function automatic logic [DW-1:0] bcdInc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Command decode, auto-advance, handshake sequencing and RUN-time counters.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        chip_d     = chip_q;
        auto_d     = auto_q;
        holdCnt_d  = holdCnt_q;
        unitCnt_d  = unitCnt_q;
        blinkCnt_d = blinkCnt_q;
        bcd_d      = bcd_q;
        mark_d     = mark_q;
        goReq      = 1'b0;

        if (riseChip) begin
            chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + CW'(1);
            goReq  = 1'b1;
        end

        if (riseAuto) begin
            step_d = '0;
            auto_d = 1'b1;
            goReq  = 1'b1;
        end else begin
            if (riseRetest || (riseUp && riseDown)) begin
                auto_d = 1'b0;
                goReq  = 1'b1;
            end
            if (riseUp && !riseDown && (step_q != STEP_LAST)) begin
                step_d = step_q + SW'(1);
                auto_d = 1'b0;
                goReq  = 1'b1;
            end
            if (riseDown && !riseUp && (step_q != '0)) begin
                step_d = step_q - SW'(1);
                auto_d = 1'b0;
                goReq  = 1'b1;
            end
        end

        if (goReq || autoAdvance) begin
            if (!goReq) begin
                step_d = step_q + SW'(1);
            end
            state_d    = REQ;
            unitCnt_d  = '0;
            blinkCnt_d = '0;
            bcd_d      = '0;
            mark_d     = '0;
        end else begin
            case (state_q)
                REQ: begin
                    unitCnt_d  = '0;
                    blinkCnt_d = '0;
                    bcd_d      = '0;
                    mark_d     = '0;
                    if (recfg_done) begin
                        state_d   = HOLD;
                        holdCnt_d = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    unitCnt_d  = '0;
                    blinkCnt_d = '0;
                    bcd_d      = '0;
                    mark_d     = '0;
                    if (holdCnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        holdCnt_d = holdCnt_q - HW'(1);
                    end
                end
                RUN: begin
                    if (unitCnt_q == UNIT_LAST) begin
                        unitCnt_d = '0;
                        bcd_d     = bcdInc(bcd_q);
                    end else begin
                        unitCnt_d = unitCnt_q + UW'(1);
                    end
                    if (blinkCnt_q == BLINK_LAST) begin
                        blinkCnt_d = '0;
                        mark_d     = mark_q + 3'd1;
                    end else begin
                        blinkCnt_d = blinkCnt_q + BW'(1);
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State register; reset wins over any command seen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            step_q     <= '0;
            chip_q     <= '0;
            auto_q     <= AUTO_RESET;
            holdCnt_q  <= '0;
            unitCnt_q  <= '0;
            blinkCnt_q <= '0;
            bcd_q      <= '0;
            mark_q     <= '0;
            cmdHist_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            chip_q     <= chip_d;
            auto_q     <= auto_d;
            holdCnt_q  <= holdCnt_d;
            unitCnt_q  <= unitCnt_d;
            blinkCnt_q <= blinkCnt_d;
            bcd_q      <= bcd_d;
            mark_q     <= mark_d;
            cmdHist_q  <= {cmd_up, cmd_down, cmd_retest, cmd_chip};
        end
    end

    assign recfg_req   = (state_q == REQ);
    assign tester_rst  = (state_q != RUN);
    assign step        = step_q;
    assign chip        = chip_q;
    assign auto_mode   = auto_q;
    assign elapsed_bcd = bcd_q;
    assign mark_phase  = mark_q;

endmodule

// File: tb/tb_memtest_sweep_ctrl.sv
// tb_memtest_sweep_ctrl
// Scoreboard bench for memtest_sweep_ctrl with small time bases
// (UNIT_CYCLES=10, BLINK_CYCLES=3, HOLD_CYCLES=4, NUM_STEPS=6, NUM_CHIPS=3).
// Expectations follow MEMTEST_AUTOSWEEP_EN when it is defined for the build.

module tb_memtest_sweep_ctrl;

    typedef logic [18:0] vec_t;

    typedef struct {
        logic       rst;
        logic [4:0] cmd;
        logic       done;
        logic [1:0] pf;
        vec_t       exp;
        string      tag;
    } rowT;

    typedef struct {
        string name;
        vec_t  val;
    } expT;

    localparam logic [4:0] NC = 5'b00000;
    localparam logic [4:0] UP = 5'b10000;
    localparam logic [4:0] DN = 5'b01000;
    localparam logic [4:0] RT = 5'b00100;
    localparam logic [4:0] AU = 5'b00010;
    localparam logic [4:0] CH = 5'b00001;

`ifdef MEMTEST_AUTOSWEEP_EN
    localparam logic A = 1'b1;
`else
    localparam logic A = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cmd_up, cmd_down, cmd_retest, cmd_auto, cmd_chip;
    logic [31:0] pass_count, fail_count;
    logic        recfg_done;
    logic        recfg_req;
    logic [2:0]  step;
    logic [1:0]  chip;
    logic        auto_mode;
    logic        tester_rst;
    logic [7:0]  elapsed_bcd;
    logic [2:0]  mark_phase;

    int  nAsserts = 0;
    int  nFails   = 0;
    expT sb[$];

    memtest_sweep_ctrl #(
        .NUM_STEPS    (6),
        .NUM_CHIPS    (3),
        .BCD_DIGITS   (2),
        .UNIT_CYCLES  (64'd10),
        .BLINK_CYCLES (64'd3),
        .HOLD_CYCLES  (64'd4),
        .AUTO_MIN_PASS(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_up     (cmd_up),
        .cmd_down   (cmd_down),
        .cmd_retest (cmd_retest),
        .cmd_auto   (cmd_auto),
        .cmd_chip   (cmd_chip),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .recfg_done (recfg_done),
        .recfg_req  (recfg_req),
        .step       (step),
        .chip       (chip),
        .auto_mode  (auto_mode),
        .tester_rst (tester_rst),
        .elapsed_bcd(elapsed_bcd),
        .mark_phase (mark_phase)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: got no finish, required finish before 5 ms");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t expv(input logic req, input logic trst, input logic au,
                                  input logic [2:0] s, input logic [1:0] c,
                                  input logic [7:0] b, input logic [2:0] m);
        return {req, trst, au, s, c, b, m};
    endfunction

    function automatic vec_t obs();
        return {recfg_req, tester_rst, auto_mode, step, chip, elapsed_bcd, mark_phase};
    endfunction

    function automatic rowT mkRow(input logic r, input logic [4:0] cmd, input logic d,
                                  input logic [1:0] pf, input vec_t e, input string tag);
        rowT x;
        x.rst  = r;
        x.cmd  = cmd;
        x.done = d;
        x.pf   = pf;
        x.exp  = e;
        x.tag  = tag;
        return x;
    endfunction

    function automatic logic [7:0] bcdOf(input int n);
        int u;
        u = (n / 10) % 100;
        return {4'(u / 10), 4'(u % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveRow(input rowT r);
        reset = r.rst;
        {cmd_up, cmd_down, cmd_retest, cmd_auto, cmd_chip} = r.cmd;
        recfg_done = r.done;
        pass_count = {31'd0, r.pf[1]};
        fail_count = {31'd0, r.pf[0]};
    endtask

    task automatic applyStimulus_goRun();
        reset = 1'b1;
        {cmd_up, cmd_down, cmd_retest, cmd_auto, cmd_chip} = NC;
        recfg_done = 1'b0;
        pass_count = 32'd0;
        fail_count = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        recfg_done = 1'b1;
        tick();
        recfg_done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rowT rows[$];
        expT ent;
        vec_t got;
        rows.push_back(mkRow(1, NC, 0, 2'b00, expv(1, 1, A, 0, 0, 0, 0), "reset values"));
        rows.push_back(mkRow(1, UP | CH, 1, 2'b11, expv(1, 1, A, 0, 0, 0, 0), "reset ignores commands"));
        for (int i = 0; i < 4; i++)
            rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, A, 0, 0, 0, 0), $sformatf("req wait %0d", i)));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, A, 0, 0, 0, 0), "done to hold"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 1, A, 0, 0, 0, 0), "hold 1"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, A, 0, 0, 0, 0), "hold 2 done ignored"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 1, A, 0, 0, 0, 0), "hold 3"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 0, A, 0, 0, 0, 0), "run after hold"));
        foreach (rows[i]) begin
            driveRow(rows[i]);
            ent.name = rows[i].tag;
            ent.val  = rows[i].exp;
            sb.push_back(ent);
            tick();
            ent = sb.pop_front();
            got = obs();
            nAsserts++;
            if (got !== ent.val) begin
                nFails++;
                $display("[TB] FAIL %s: got %h, expected %h", ent.name, got, ent.val);
            end
        end
    endtask

    task automatic test_elapsed();
        expT ent;
        vec_t got;
        {cmd_up, cmd_down, cmd_retest, cmd_auto, cmd_chip} = NC;
        pass_count = 32'd0;
        fail_count = 32'd0;
        for (int n = 1; n <= 1000; n++) begin
            recfg_done = (n % 7 == 0);
            ent.name = $sformatf("elapsed n=%0d", n);
            ent.val  = expv(0, 0, A, 0, 0, bcdOf(n), 3'((n / 3) % 8));
            sb.push_back(ent);
            tick();
            ent = sb.pop_front();
            got = obs();
            nAsserts++;
            if (got !== ent.val) begin
                nFails++;
                $display("[TB] FAIL %s: got %h, expected %h", ent.name, got, ent.val);
            end
        end
        recfg_done = 1'b0;
    endtask

    task automatic test_commands();
        rowT rows[$];
        expT ent;
        vec_t got;
        applyStimulus_goRun();
        rows.push_back(mkRow(0, DN, 0, 2'b00, expv(0, 0, A, 0, 0, 0, 0), "down at 0 ignored"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 0, A, 0, 0, 0, 0), "still run"));
        rows.push_back(mkRow(0, UP, 0, 2'b00, expv(1, 1, 0, 1, 0, 0, 0), "up to 1"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 1, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, UP, 0, 2'b00, expv(1, 1, 0, 2, 0, 0, 0), "up to 2"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 2, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, UP, 0, 2'b00, expv(1, 1, 0, 3, 0, 0, 0), "up to 3"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 3, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, UP | DN, 0, 2'b00, expv(1, 1, 0, 3, 0, 0, 0), "up+down retest"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 3, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, 0, 3, 0, 0, 0), "to hold"));
        rows.push_back(mkRow(0, CH, 0, 2'b00, expv(1, 1, 0, 3, 1, 0, 0), "chip in hold"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 3, 1, 0, 0), "idle"));
        rows.push_back(mkRow(0, CH, 0, 2'b00, expv(1, 1, 0, 3, 2, 0, 0), "chip to 2"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 3, 2, 0, 0), "idle"));
        rows.push_back(mkRow(0, CH | UP, 0, 2'b00, expv(1, 1, 0, 4, 0, 0, 0), "chip wrap with up"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 4, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, UP, 0, 2'b00, expv(1, 1, 0, 5, 0, 0, 0), "up to last"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, 0, 5, 0, 0, 0), "to hold"));
        for (int i = 0; i < 3; i++)
            rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 1, 0, 5, 0, 0, 0), $sformatf("hold %0d", i)));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 0, 0, 5, 0, 0, 0), "run at last"));
        rows.push_back(mkRow(0, UP, 0, 2'b00, expv(0, 0, 0, 5, 0, 0, 0), "up at last ignored"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 0, 0, 5, 0, 0, 0), "done in run ignored"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 0, 0, 5, 0, 0, 1), "mark phase 1"));
        rows.push_back(mkRow(0, RT, 0, 2'b00, expv(1, 1, 0, 5, 0, 0, 0), "retest"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 5, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, DN, 0, 2'b00, expv(1, 1, 0, 4, 0, 0, 0), "down to 4"));
        foreach (rows[i]) begin
            driveRow(rows[i]);
            ent.name = rows[i].tag;
            ent.val  = rows[i].exp;
            sb.push_back(ent);
            tick();
            ent = sb.pop_front();
            got = obs();
            nAsserts++;
            if (got !== ent.val) begin
                nFails++;
                $display("[TB] FAIL %s: got %h, expected %h", ent.name, got, ent.val);
            end
        end
    endtask

    task automatic test_auto();
        rowT rows[$];
        expT ent;
        vec_t got;
        applyStimulus_goRun();
`ifdef MEMTEST_AUTOSWEEP_EN
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(1, 1, 1, 1, 0, 0, 0), "auto advance to 1"));
        for (int s = 1; s <= 4; s++) begin
            rows.push_back(mkRow(0, NC, 1, 2'b11, expv(0, 1, 1, 3'(s), 0, 0, 0), "auto to hold"));
            for (int h = 0; h < 3; h++)
                rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 1, 1, 3'(s), 0, 0, 0), "auto hold"));
            rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 1, 3'(s), 0, 0, 0), "auto run entry"));
            rows.push_back(mkRow(0, NC, 0, 2'b11, expv(1, 1, 1, 3'(s + 1), 0, 0, 0),
                                 $sformatf("auto advance to %0d", s + 1)));
        end
        rows.push_back(mkRow(0, NC, 1, 2'b11, expv(0, 1, 1, 5, 0, 0, 0), "last to hold"));
        for (int h = 0; h < 3; h++)
            rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 1, 1, 5, 0, 0, 0), "last hold"));
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 1, 5, 0, 0, 0), "last run entry"));
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 1, 5, 0, 0, 0), "auto stops at last"));
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 1, 5, 0, 0, 0), "auto stays at last"));
        rows.push_back(mkRow(0, DN, 0, 2'b00, expv(1, 1, 0, 4, 0, 0, 0), "down clears auto"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 4, 0, 0, 0), "idle"));
        rows.push_back(mkRow(0, AU | UP, 0, 2'b00, expv(1, 1, 1, 0, 0, 0, 0), "auto beats up"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, 1, 0, 0, 0, 0), "to hold"));
        for (int h = 0; h < 3; h++)
            rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 1, 1, 0, 0, 0, 0), "hold"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(0, 0, 1, 0, 0, 0, 0), "run entry"));
        rows.push_back(mkRow(0, NC, 0, 2'b10, expv(0, 0, 1, 0, 0, 0, 0), "no fail no advance"));
        rows.push_back(mkRow(0, NC, 0, 2'b01, expv(0, 0, 1, 0, 0, 0, 0), "pass below min"));
        rows.push_back(mkRow(0, RT, 0, 2'b11, expv(1, 1, 0, 0, 0, 0, 0), "user beats auto"));
`else
        rows.push_back(mkRow(0, AU, 0, 2'b00, expv(0, 0, 0, 0, 0, 0, 0), "auto cmd ignored"));
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 0, 0, 0, 0, 0), "no advance without feature"));
        rows.push_back(mkRow(0, NC, 0, 2'b11, expv(0, 0, 0, 0, 0, 0, 1), "run continues"));
`endif
        foreach (rows[i]) begin
            driveRow(rows[i]);
            ent.name = rows[i].tag;
            ent.val  = rows[i].exp;
            sb.push_back(ent);
            tick();
            ent = sb.pop_front();
            got = obs();
            nAsserts++;
            if (got !== ent.val) begin
                nFails++;
                $display("[TB] FAIL %s: got %h, expected %h", ent.name, got, ent.val);
            end
        end
    endtask

    task automatic test_reset_hold();
        rowT rows[$];
        expT ent;
        vec_t got;
        applyStimulus_goRun();
        rows.push_back(mkRow(0, UP | CH, 0, 2'b00, expv(1, 1, 0, 1, 1, 0, 0), "up and chip"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, 0, 1, 1, 0, 0), "idle"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, 0, 1, 1, 0, 0), "to hold"));
        rows.push_back(mkRow(1, UP, 1, 2'b00, expv(1, 1, A, 0, 0, 0, 0), "reset in hold"));
        rows.push_back(mkRow(0, NC, 0, 2'b00, expv(1, 1, A, 0, 0, 0, 0), "req after reset"));
        rows.push_back(mkRow(0, NC, 1, 2'b00, expv(0, 1, A, 0, 0, 0, 0), "hold after reset"));
        foreach (rows[i]) begin
            driveRow(rows[i]);
            ent.name = rows[i].tag;
            ent.val  = rows[i].exp;
            sb.push_back(ent);
            tick();
            ent = sb.pop_front();
            got = obs();
            nAsserts++;
            if (got !== ent.val) begin
                nFails++;
                $display("[TB] FAIL %s: got %h, expected %h", ent.name, got, ent.val);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        reset      = 1'b1;
        {cmd_up, cmd_down, cmd_retest, cmd_auto, cmd_chip} = NC;
        recfg_done = 1'b0;
        pass_count = 32'd0;
        fail_count = 32'd0;
        #1;
        test_reset();
        test_elapsed();
        test_commands();
        test_auto();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
